// File: rtl/ram_loader_pkg.sv
// Shared definitions for the CPU blocks: RAM loader state encoding and the
// default polarity of the external RAM direction line.
package ram_loader_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_WAIT,
      ST_WRITE,
      ST_RELEASE,
      ST_DONE
   } state_t;

   localparam logic WRITE_LEVEL_DEFAULT = 1'b1;

endpackage

// File: rtl/ram_loader.sv
// Streams program words into the external RAM while holding the core in HALT.
// Each accepted word costs one WAIT cycle plus one single-cycle WRITE strobe.
module ram_loader
   import ram_loader_pkg::*;
#(
   parameter int   ADDR_W      = 16,
   parameter int   DATA_W      = 16,
   parameter logic WRITE_LEVEL = WRITE_LEVEL_DEFAULT
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              START,
   input  logic [ADDR_W-1:0] BASE_ADDR,
   input  logic [15:0]       LENGTH,
   input  logic              ABORT,
   input  logic [DATA_W-1:0] WORD_DATA,
   input  logic              WORD_VALID,
   output logic              WORD_READY,
   output logic              HALT,
   output logic [ADDR_W-1:0] ADDRESS,
   output logic [DATA_W-1:0] DATA,
   output logic              EXT_RAM_RW,
   output logic              EXT_RAM_EN,
   output logic              BUSY,
   output logic              DONE,
   output logic              ERR,
   output logic [DATA_W-1:0] CHECKSUM
);

   state_t            state, state_nx;
   logic [ADDR_W-1:0] base_q;
   logic [15:0]       len_q;
   logic [15:0]       idx_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] data_q;
   logic [DATA_W-1:0] csum_q;
   logic              err_q;
   logic              last_word;

   assign last_word = ((idx_q + 16'd1) == len_q);

   // NOTE: registered state uses non-blocking assignments so every flop samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge CLK) begin
      if (!RST) begin
         state  <= ST_IDLE;
         base_q <= '0;
         len_q  <= '0;
         idx_q  <= '0;
         addr_q <= '0;
         data_q <= '0;
         csum_q <= '0;
         err_q  <= 1'b0;
      end else begin
         state <= state_nx;
         unique case (state)
            ST_IDLE: begin
               if (START) begin
                  base_q <= BASE_ADDR;
                  len_q  <= LENGTH;
                  idx_q  <= '0;
                  csum_q <= '0;
                  err_q  <= 1'b0;
               end
            end
            ST_SETUP: begin
               if (ABORT) err_q <= 1'b1;
            end
            ST_WAIT: begin
               // ABORT takes priority: a word offered alongside it is dropped.
               if (ABORT) begin
                  err_q <= 1'b1;
               end else if (WORD_VALID) begin
                  data_q <= WORD_DATA;
                  addr_q <= base_q + ADDR_W'(idx_q);
               end
            end
            ST_WRITE: begin
               csum_q <= csum_q + data_q;
               idx_q  <= idx_q + 16'd1;
               if (ABORT) err_q <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   // NOTE: defaults first so every path assigns state_nx and no latch is inferred.
   always_comb begin
      state_nx = state;
      unique case (state)
         ST_IDLE:    if (START) state_nx = (LENGTH == 16'd0) ? ST_DONE : ST_SETUP;
         ST_SETUP:   state_nx = ABORT ? ST_RELEASE : ST_WAIT;
         ST_WAIT: begin
            if (ABORT)           state_nx = ST_RELEASE;
            else if (WORD_VALID) state_nx = ST_WRITE;
         end
         ST_WRITE:   state_nx = (ABORT || last_word) ? ST_RELEASE : ST_WAIT;
         ST_RELEASE: state_nx = ST_DONE;
         ST_DONE:    state_nx = ST_IDLE;
         default:    state_nx = ST_IDLE;
      endcase
   end

   // Control outputs decode straight from the state register, so they are glitch-free.
   assign WORD_READY = (state == ST_WAIT);
   assign HALT       = (state == ST_SETUP) || (state == ST_WAIT) ||
                       (state == ST_WRITE) || (state == ST_RELEASE);
   assign EXT_RAM_EN = (state == ST_WRITE);
   assign EXT_RAM_RW = (state == ST_WRITE) ? WRITE_LEVEL : ~WRITE_LEVEL;
   assign BUSY       = (state != ST_IDLE);
   assign DONE       = (state == ST_DONE);
   assign ADDRESS    = addr_q;
   assign DATA       = data_q;
   assign ERR        = err_q;
   assign CHECKSUM   = csum_q;

endmodule

// File: tb/tb_ram_loader.sv
// Directed bench for ram_loader: one task per scenario, inputs driven and
// outputs sampled on the falling edge, a posedge monitor logs strobes.
module tb_ram_loader;

   logic        CLK = 1'b0;
   logic        RST;
   logic        START;
   logic [15:0] BASE_ADDR;
   logic [15:0] LENGTH;
   logic        ABORT;
   logic [15:0] WORD_DATA;
   logic        WORD_VALID;
   logic        WORD_READY;
   logic        HALT;
   logic [15:0] ADDRESS;
   logic [15:0] DATA;
   logic        EXT_RAM_RW;
   logic        EXT_RAM_EN;
   logic        BUSY;
   logic        DONE;
   logic        ERR;
   logic [15:0] CHECKSUM;

   int checks = 0;
   int errors = 0;

   logic [15:0] wr_addr[$];
   logic [15:0] wr_data[$];
   int          done_cnt = 0;
   int          halt_cnt = 0;

   ram_loader #(.ADDR_W(16), .DATA_W(16), .WRITE_LEVEL(1'b1)) dut (
      .CLK(CLK), .RST(RST), .START(START), .BASE_ADDR(BASE_ADDR), .LENGTH(LENGTH),
      .ABORT(ABORT), .WORD_DATA(WORD_DATA), .WORD_VALID(WORD_VALID),
      .WORD_READY(WORD_READY), .HALT(HALT), .ADDRESS(ADDRESS), .DATA(DATA),
      .EXT_RAM_RW(EXT_RAM_RW), .EXT_RAM_EN(EXT_RAM_EN), .BUSY(BUSY), .DONE(DONE),
      .ERR(ERR), .CHECKSUM(CHECKSUM)
   );

   always #5 CLK = ~CLK;

   // Sees the values held during the cycle that is ending.
   always @(posedge CLK) begin
      if (EXT_RAM_EN === 1'b1) begin
         wr_addr.push_back(ADDRESS);
         wr_data.push_back(DATA);
      end
      if (DONE === 1'b1) done_cnt++;
      if (HALT === 1'b1) halt_cnt++;
   end

   initial begin
      #500000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(negedge CLK);
   endtask

   task automatic clear_mon();
      wr_addr.delete();
      wr_data.delete();
      done_cnt = 0;
      halt_cnt = 0;
   endtask

   task automatic start_load(input logic [15:0] base, input logic [15:0] len);
      BASE_ADDR = base;
      LENGTH    = len;
      START     = 1'b1;
      step();
      START     = 1'b0;
   endtask

   task automatic feed_word(input logic [15:0] w, input int stall, input logic [15:0] prev,
                            input string tag);
      int budget = 0;
      while (WORD_READY !== 1'b1 && budget < 20) begin
         step();
         budget++;
      end
      checks++;
      if (WORD_READY !== 1'b1) begin
         errors++;
         $display("FAIL %s_ready_timeout got %b exp 1", tag, WORD_READY);
      end
      for (int s = 0; s < stall; s++) begin
         checks++;
         if ({HALT, EXT_RAM_EN, WORD_READY, DATA} !== {1'b1, 1'b0, 1'b1, prev}) begin
            errors++;
            $display("FAIL %s_stall%0d got halt=%b en=%b rdy=%b data=%h exp 1 0 1 %h",
                     tag, s, HALT, EXT_RAM_EN, WORD_READY, DATA, prev);
         end
         step();
      end
      WORD_VALID = 1'b1;
      WORD_DATA  = w;
      step();
      WORD_VALID = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      int budget = 0;
      while (DONE !== 1'b1 && budget < 30) begin
         step();
         budget++;
      end
      checks++;
      if (DONE !== 1'b1) begin
         errors++;
         $display("FAIL %s_done_timeout got %b exp 1", tag, DONE);
      end
      step();
      step();
   endtask

   task automatic check_reset_values(input string tag);
      checks++;
      if ({HALT, EXT_RAM_EN, EXT_RAM_RW, WORD_READY, BUSY, DONE, ERR} !== 7'b0) begin
         errors++;
         $display("FAIL %s_ctrl got halt=%b en=%b rw=%b rdy=%b busy=%b done=%b err=%b exp all 0",
                  tag, HALT, EXT_RAM_EN, EXT_RAM_RW, WORD_READY, BUSY, DONE, ERR);
      end
      checks++;
      if ({ADDRESS, DATA, CHECKSUM} !== 48'h0) begin
         errors++;
         $display("FAIL %s_regs got addr=%h data=%h csum=%h exp 0 0 0",
                  tag, ADDRESS, DATA, CHECKSUM);
      end
   endtask

   task automatic test_reset();
      RST = 1'b0; START = 1'b0; BASE_ADDR = '0; LENGTH = '0;
      ABORT = 1'b0; WORD_DATA = '0; WORD_VALID = 1'b0;
      step();
      step();
      check_reset_values("reset");
      RST = 1'b1;
      step();
   endtask

   task automatic test_back_to_back();
      clear_mon();
      start_load(16'h0010, 16'd3);
      checks++;
      if ({HALT, EXT_RAM_EN, BUSY, WORD_READY} !== 4'b1010) begin
         errors++;
         $display("FAIL b2b_setup got halt=%b en=%b busy=%b rdy=%b exp 1 0 1 0",
                  HALT, EXT_RAM_EN, BUSY, WORD_READY);
      end
      WORD_VALID = 1'b1;
      WORD_DATA  = 16'h1111;
      step();
      checks++;
      if ({WORD_READY, EXT_RAM_EN} !== 2'b10) begin
         errors++;
         $display("FAIL b2b_wait1 got rdy=%b en=%b exp 1 0", WORD_READY, EXT_RAM_EN);
      end
      step();
      checks++;
      if ({EXT_RAM_EN, EXT_RAM_RW, WORD_READY, ADDRESS, DATA} !== {3'b110, 16'h0010, 16'h1111}) begin
         errors++;
         $display("FAIL b2b_write1 got en=%b rw=%b rdy=%b addr=%h data=%h exp 1 1 0 0010 1111",
                  EXT_RAM_EN, EXT_RAM_RW, WORD_READY, ADDRESS, DATA);
      end
      WORD_DATA = 16'h2222;
      step();
      checks++;
      if ({EXT_RAM_EN, EXT_RAM_RW, CHECKSUM} !== {2'b00, 16'h1111}) begin
         errors++;
         $display("FAIL b2b_wait2 got en=%b rw=%b csum=%h exp 0 0 1111",
                  EXT_RAM_EN, EXT_RAM_RW, CHECKSUM);
      end
      // A START while busy must not disturb the running load.
      START = 1'b1; BASE_ADDR = 16'h0500; LENGTH = 16'd7;
      step();
      START = 1'b0;
      checks++;
      if ({ADDRESS, DATA} !== {16'h0011, 16'h2222}) begin
         errors++;
         $display("FAIL b2b_write2 got addr=%h data=%h exp 0011 2222", ADDRESS, DATA);
      end
      WORD_DATA = 16'h3333;
      step();
      step();
      checks++;
      if ({EXT_RAM_EN, ADDRESS, DATA} !== {1'b1, 16'h0012, 16'h3333}) begin
         errors++;
         $display("FAIL b2b_write3 got en=%b addr=%h data=%h exp 1 0012 3333",
                  EXT_RAM_EN, ADDRESS, DATA);
      end
      WORD_VALID = 1'b0;
      step();
      checks++;
      if ({HALT, EXT_RAM_EN, DONE, CHECKSUM} !== {3'b100, 16'h6666}) begin
         errors++;
         $display("FAIL b2b_release got halt=%b en=%b done=%b csum=%h exp 1 0 0 6666",
                  HALT, EXT_RAM_EN, DONE, CHECKSUM);
      end
      step();
      checks++;
      if ({DONE, HALT, BUSY} !== 3'b101) begin
         errors++;
         $display("FAIL b2b_done got done=%b halt=%b busy=%b exp 1 0 1", DONE, HALT, BUSY);
      end
      step();
      checks++;
      if ({DONE, BUSY} !== 2'b00) begin
         errors++;
         $display("FAIL b2b_idle got done=%b busy=%b exp 0 0", DONE, BUSY);
      end
      step();
      checks++;
      if (wr_addr.size() != 3 || done_cnt != 1 || halt_cnt != 8) begin
         errors++;
         $display("FAIL b2b_counts got writes=%0d dones=%0d halt_cycles=%0d exp 3 1 8",
                  wr_addr.size(), done_cnt, halt_cnt);
      end else begin
         checks++;
         if ({wr_addr[0], wr_addr[1], wr_addr[2]} !== {16'h0010, 16'h0011, 16'h0012}) begin
            errors++;
            $display("FAIL b2b_addrs got %h %h %h exp 0010 0011 0012",
                     wr_addr[0], wr_addr[1], wr_addr[2]);
         end
      end
   endtask

   task automatic test_wrap();
      clear_mon();
      start_load(16'hFFFF, 16'd2);
      feed_word(16'hAAAA, 0, 16'h0000, "wrap");
      feed_word(16'h0001, 0, 16'hAAAA, "wrap");
      wait_done("wrap");
      checks++;
      if (wr_addr.size() != 2) begin
         errors++;
         $display("FAIL wrap_count got %0d exp 2", wr_addr.size());
      end else begin
         checks++;
         if ({wr_addr[0], wr_addr[1]} !== {16'hFFFF, 16'h0000}) begin
            errors++;
            $display("FAIL wrap_addrs got %h %h exp ffff 0000", wr_addr[0], wr_addr[1]);
         end
      end
      checks++;
      if ({ERR, CHECKSUM} !== {1'b0, 16'hAAAB}) begin
         errors++;
         $display("FAIL wrap_csum got err=%b csum=%h exp 0 aaab", ERR, CHECKSUM);
      end
   endtask

   task automatic test_len_zero();
      clear_mon();
      start_load(16'h1234, 16'd0);
      checks++;
      if ({DONE, HALT, BUSY} !== 3'b101) begin
         errors++;
         $display("FAIL len0_done got done=%b halt=%b busy=%b exp 1 0 1", DONE, HALT, BUSY);
      end
      step();
      checks++;
      if ({DONE, BUSY} !== 2'b00) begin
         errors++;
         $display("FAIL len0_idle got done=%b busy=%b exp 0 0", DONE, BUSY);
      end
      step();
      checks++;
      if (halt_cnt != 0 || wr_addr.size() != 0 || done_cnt != 1) begin
         errors++;
         $display("FAIL len0_counts got halt_cycles=%0d writes=%0d dones=%0d exp 0 0 1",
                  halt_cnt, wr_addr.size(), done_cnt);
      end
   endtask

   task automatic test_abort();
      clear_mon();
      start_load(16'h0100, 16'd4);
      feed_word(16'h0F0F, 0, 16'h0000, "abort");
      step();
      checks++;
      if (WORD_READY !== 1'b1) begin
         errors++;
         $display("FAIL abort_wait got rdy=%b exp 1", WORD_READY);
      end
      ABORT = 1'b1; WORD_VALID = 1'b1; WORD_DATA = 16'hBEEF;
      step();
      ABORT = 1'b0; WORD_VALID = 1'b0;
      checks++;
      if ({HALT, ERR, EXT_RAM_EN, WORD_READY} !== 4'b1100) begin
         errors++;
         $display("FAIL abort_release got halt=%b err=%b en=%b rdy=%b exp 1 1 0 0",
                  HALT, ERR, EXT_RAM_EN, WORD_READY);
      end
      step();
      checks++;
      if ({HALT, DONE} !== 2'b01) begin
         errors++;
         $display("FAIL abort_done got halt=%b done=%b exp 0 1", HALT, DONE);
      end
      step();
      step();
      checks++;
      if (wr_addr.size() != 1 || CHECKSUM !== 16'h0F0F || DATA !== 16'h0F0F) begin
         errors++;
         $display("FAIL abort_writes got writes=%0d csum=%h data=%h exp 1 0f0f 0f0f",
                  wr_addr.size(), CHECKSUM, DATA);
      end
      ABORT = 1'b1;
      step();
      ABORT = 1'b0;
      checks++;
      if ({BUSY, ERR} !== 2'b01) begin
         errors++;
         $display("FAIL abort_idle got busy=%b err=%b exp 0 1", BUSY, ERR);
      end
   endtask

   task automatic test_stall();
      clear_mon();
      start_load(16'h2000, 16'd2);
      checks++;
      if (ERR !== 1'b0) begin
         errors++;
         $display("FAIL stall_err_clear got %b exp 0", ERR);
      end
      feed_word(16'h1234, 0, 16'h0000, "stall");
      feed_word(16'h4321, 5, 16'h1234, "stall");
      wait_done("stall");
      checks++;
      if (wr_addr.size() != 2 || halt_cnt != 11) begin
         errors++;
         $display("FAIL stall_counts got writes=%0d halt_cycles=%0d exp 2 11",
                  wr_addr.size(), halt_cnt);
      end else begin
         checks++;
         if ({wr_addr[1], wr_data[1]} !== {16'h2001, 16'h4321}) begin
            errors++;
            $display("FAIL stall_write2 got addr=%h data=%h exp 2001 4321", wr_addr[1], wr_data[1]);
         end
      end
      checks++;
      if (CHECKSUM !== 16'h5555) begin
         errors++;
         $display("FAIL stall_csum got %h exp 5555", CHECKSUM);
      end
   endtask

   task automatic test_reset_mid_write();
      clear_mon();
      start_load(16'h0030, 16'd3);
      feed_word(16'h7777, 0, 16'h0000, "rstmid");
      checks++;
      if (EXT_RAM_EN !== 1'b1) begin
         errors++;
         $display("FAIL rstmid_in_write got en=%b exp 1", EXT_RAM_EN);
      end
      RST = 1'b0;
      step();
      check_reset_values("rstmid");
      RST = 1'b1;
      step();
      step();
      step();
      checks++;
      if (done_cnt != 0 || BUSY !== 1'b0) begin
         errors++;
         $display("FAIL rstmid_no_done got dones=%0d busy=%b exp 0 0", done_cnt, BUSY);
      end
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_wrap();
      test_len_zero();
      test_abort();
      test_stall();
      test_reset_mid_write();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
